// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_prog_loader
// Brief    : UART 8N1 boot loader packing bytes little-endian into 32-bit
//            instruction-memory writes, holding the core in reset meanwhile.
// Revision : 1.0 - initial release
// ============================================================================
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 13
) (
    input  logic              clk,
    input  logic              rstB,
    input  logic              progEn,
    input  logic              rx,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWdata,
    output logic              cpuRstB,
    output logic              frameErr,
    output logic [ADDR_W:0]   wordCnt
);

    localparam int              c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0] c_WCNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic               r_rx_meta, r_rx_s, r_rx_prev;
    logic               r_prog_meta, r_prog_s, r_prog_prev;
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [1:0]         r_lane;
    logic [31:0]        r_buf;
    logic [ADDR_W-1:0]  r_ptr;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic               r_cpu_rst_b;
    logic               r_frame_err;
    logic [ADDR_W:0]    r_word_cnt;

    logic        w_rx_fall, w_prog_rise, w_prog_fall, w_flush;
    logic        w_stop_tick, w_byte_ok, w_byte_bad, w_full_word, w_write;
    logic [31:0] w_wdata;

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_prog_meta <= 1'b0;
            r_prog_s    <= 1'b0;
            r_prog_prev <= 1'b0;
        end else begin
            r_rx_meta   <= rx;
            r_rx_s      <= r_rx_meta;
            r_rx_prev   <= r_rx_s;
            r_prog_meta <= progEn;
            r_prog_s    <= r_prog_meta;
            r_prog_prev <= r_prog_s;
        end
    end

    assign w_rx_fall   = r_rx_prev & ~r_rx_s;
    assign w_prog_rise = r_prog_s & ~r_prog_prev;
    assign w_prog_fall = ~r_prog_s & r_prog_prev;
    assign w_flush     = w_prog_fall & (r_lane != 2'd0);
    assign w_stop_tick = (r_state == c_STOP) && (r_cnt == c_FULL_M1) && r_prog_s;
    assign w_byte_ok   = w_stop_tick & r_rx_s;
    assign w_byte_bad  = w_stop_tick & ~r_rx_s;
    assign w_full_word = w_byte_ok & (r_lane == 2'd3);
    assign w_write     = w_flush | w_full_word;
    assign w_wdata     = w_flush ? r_buf : {r_shift, r_buf[23:0]};

    // Receiver; leaving programming mode abandons any byte in flight.
    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else if (!r_prog_s) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_rx_fall) begin
                        r_state <= c_START;
                        r_cnt   <= c_CNT_W'(1);
                    end
                end
                c_START: begin
                    if (r_cnt == c_HALF_M1) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= r_rx_s ? c_IDLE : c_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DATA: begin
                    if (r_cnt == c_FULL_M1) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_STOP: begin
                    if (r_cnt == c_FULL_M1) begin
                        r_cnt   <= '0;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Word packer, write port and session bookkeeping.
    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            r_lane      <= 2'd0;
            r_buf       <= 32'd0;
            r_ptr       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_cpu_rst_b <= 1'b0;
            r_frame_err <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            r_mem_we    <= 1'b0;
            r_cpu_rst_b <= ~(r_prog_s | w_flush);
            if (w_prog_rise) begin
                r_lane      <= 2'd0;
                r_buf       <= 32'd0;
                r_ptr       <= '0;
                r_frame_err <= 1'b0;
                r_word_cnt  <= '0;
            end else if (w_write) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_ptr;
                r_mem_wdata <= w_wdata;
                r_ptr       <= r_ptr + 1'b1;
                r_lane      <= 2'd0;
                r_buf       <= 32'd0;
                if (r_word_cnt != c_WCNT_MAX) begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
            end else if (w_byte_ok) begin
                r_buf[{r_lane, 3'b000} +: 8] <= r_shift;
                r_lane <= r_lane + 1'b1;
            end else if (w_byte_bad) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign memWe    = r_mem_we;
    assign memAddr  = r_mem_addr;
    assign memWdata = r_mem_wdata;
    assign cpuRstB  = r_cpu_rst_b;
    assign frameErr = r_frame_err;
    assign wordCnt  = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_prog_loader
// Brief    : Directed self-checking bench for uart_prog_loader (three
//            instances: full-rate timing, fast-rate image, 2-bit address wrap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_prog_loader;

    localparam int C0 = 868;
    localparam int C1 = 8;
    localparam int C2 = 8;

    logic clk = 1'b0;
    logic rstB = 1'b0;
    logic pe0 = 1'b0, rx0 = 1'b1;
    logic pe1 = 1'b0, rx1 = 1'b1;
    logic pe2 = 1'b0, rx2 = 1'b1;

    logic        we0, crb0, fe0;
    logic [12:0] addr0;
    logic [31:0] wd0;
    logic [13:0] wc0;
    logic        we1, crb1, fe1;
    logic [12:0] addr1;
    logic [31:0] wd1;
    logic [13:0] wc1;
    logic        we2, crb2, fe2;
    logic [1:0]  addr2;
    logic [31:0] wd2;
    logic [2:0]  wc2;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int          wa0[$], wt0[$], wa1[$], wa2[$];
    logic [31:0] wdq0[$], wdq1[$], wdq2[$];

    uart_prog_loader #(.CLKS_PER_BIT(C0), .ADDR_W(13)) u_dut0 (
        .clk(clk), .rstB(rstB), .progEn(pe0), .rx(rx0), .memWe(we0), .memAddr(addr0),
        .memWdata(wd0), .cpuRstB(crb0), .frameErr(fe0), .wordCnt(wc0));
    uart_prog_loader #(.CLKS_PER_BIT(C1), .ADDR_W(13)) u_dut1 (
        .clk(clk), .rstB(rstB), .progEn(pe1), .rx(rx1), .memWe(we1), .memAddr(addr1),
        .memWdata(wd1), .cpuRstB(crb1), .frameErr(fe1), .wordCnt(wc1));
    uart_prog_loader #(.CLKS_PER_BIT(C2), .ADDR_W(2)) u_dut2 (
        .clk(clk), .rstB(rstB), .progEn(pe2), .rx(rx2), .memWe(we2), .memAddr(addr2),
        .memWdata(wd2), .cpuRstB(crb2), .frameErr(fe2), .wordCnt(wc2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we0) begin wa0.push_back(int'(addr0)); wdq0.push_back(wd0); wt0.push_back(cyc); end
        if (we1) begin wa1.push_back(int'(addr1)); wdq1.push_back(wd1); end
        if (we2) begin wa2.push_back(int'(addr2)); wdq2.push_back(wd2); end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_rx(input int d, input logic v);
        case (d)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    task automatic send_byte(input int d, input logic [7:0] b, input logic stop);
        int cpb;
        cpb = (d == 0) ? C0 : ((d == 1) ? C1 : C2);
        drive_rx(d, 1'b0);
        wait_cyc(cpb);
        for (int i = 0; i < 8; i++) begin
            drive_rx(d, b[i]);
            wait_cyc(cpb);
        end
        drive_rx(d, stop);
        wait_cyc(cpb);
        drive_rx(d, 1'b1);
    endtask

    task automatic test_reset();
        rstB = 1'b0; pe1 = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        wait_cyc(3);
        n_checks++; if (we1 !== 1'b0) $display("FAIL reset_memWe: got %b want 0", we1); else n_pass++;
        n_checks++; if (addr1 !== 13'd0) $display("FAIL reset_memAddr: got %h want 0", addr1); else n_pass++;
        n_checks++; if (wd1 !== 32'd0) $display("FAIL reset_memWdata: got %h want 0", wd1); else n_pass++;
        n_checks++; if (crb1 !== 1'b0) $display("FAIL reset_cpuRstB: got %b want 0", crb1); else n_pass++;
        n_checks++; if (fe1 !== 1'b0) $display("FAIL reset_frameErr: got %b want 0", fe1); else n_pass++;
        n_checks++; if (wc1 !== 14'd0) $display("FAIL reset_wordCnt: got %0d want 0", wc1); else n_pass++;
        rstB = 1'b1;
        wait_cyc(10);
        n_checks++; if (crb1 !== 1'b0) $display("FAIL reset_cpuRstB_held: got %b want 0", crb1); else n_pass++;
    endtask

    task automatic test_single_word();
        int t0;
        pe0 = 1'b1;
        wait_cyc(5);
        rx0 = 1'b0;
        wait_cyc(100);
        rx0 = 1'b1;
        wait_cyc(600);
        n_checks++; if (wa0.size() !== 0) $display("FAIL glitch_no_write: got %0d writes want 0", wa0.size()); else n_pass++;
        n_checks++; if (fe0 !== 1'b0) $display("FAIL glitch_frameErr: got %b want 0", fe0); else n_pass++;
        send_byte(0, 8'h13, 1'b1);
        send_byte(0, 8'h00, 1'b1);
        send_byte(0, 8'h00, 1'b1);
        t0 = cyc;
        send_byte(0, 8'h00, 1'b1);
        wait_cyc(5);
        n_checks++;
        if (wa0.size() !== 1) $display("FAIL single_count: got %0d writes want 1", wa0.size());
        else n_pass++;
        if (wa0.size() >= 1) begin
            n_checks++; if (wa0[0] !== 0) $display("FAIL single_addr: got %0d want 0", wa0[0]); else n_pass++;
            n_checks++; if (wdq0[0] !== 32'h0000_0013) $display("FAIL single_data: got %h want 00000013", wdq0[0]); else n_pass++;
            n_checks++;
            if (wt0[0] !== t0 + 2 + 9 * C0 + C0 / 2)
                $display("FAIL single_latency: got cycle %0d want %0d", wt0[0], t0 + 2 + 9 * C0 + C0 / 2);
            else n_pass++;
        end
        n_checks++; if (wc0 !== 14'd1) $display("FAIL single_wordCnt: got %0d want 1", wc0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  img [256];
        logic [31:0] exp_w;
        int          bad;
        for (int i = 0; i < 256; i++) img[i] = 8'((i * 37 + 5) & 8'hFF);
        img[0] = 8'hFF; img[1] = 8'h00; img[2] = 8'hA5;
        wa1.delete(); wdq1.delete();
        for (int i = 0; i < 256; i++) send_byte(1, img[i], 1'b1);
        wait_cyc(5);
        n_checks++; if (wa1.size() !== 64) $display("FAIL image_count: got %0d writes want 64", wa1.size()); else n_pass++;
        bad = 0;
        for (int k = 0; k < 64 && k < wa1.size(); k++) begin
            exp_w = {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]};
            n_checks++;
            if (wa1[k] !== k || wdq1[k] !== exp_w) begin
                $display("FAIL image_word%0d: got addr %0d data %h want addr %0d data %h", k, wa1[k], wdq1[k], k, exp_w);
                bad++;
            end else n_pass++;
        end
        n_checks++; if (wc1 !== 14'd64) $display("FAIL image_wordCnt: got %0d want 64", wc1); else n_pass++;
        pe1 = 1'b0;
        wait_cyc(2);
        n_checks++; if (crb1 !== 1'b0) $display("FAIL image_cpuRstB_early: got %b want 0", crb1); else n_pass++;
        wait_cyc(1);
        n_checks++; if (crb1 !== 1'b1) $display("FAIL image_cpuRstB_release: got %b want 1", crb1); else n_pass++;
        wait_cyc(5);
        n_checks++; if (wa1.size() !== 64) $display("FAIL image_no_flush: got %0d writes want 64", wa1.size()); else n_pass++;
    endtask

    task automatic test_frame_glitch();
        pe1 = 1'b1;
        wait_cyc(5);
        wa1.delete(); wdq1.delete();
        n_checks++; if (wc1 !== 14'd0) $display("FAIL session_wordCnt_clear: got %0d want 0", wc1); else n_pass++;
        send_byte(1, 8'h5A, 1'b0);
        wait_cyc(5);
        n_checks++; if (fe1 !== 1'b1) $display("FAIL frame_err_set: got %b want 1", fe1); else n_pass++;
        rx1 = 1'b0;
        wait_cyc(2);
        rx1 = 1'b1;
        wait_cyc(20);
        n_checks++; if (wa1.size() !== 0) $display("FAIL frame_no_write: got %0d writes want 0", wa1.size()); else n_pass++;
        send_byte(1, 8'hDE, 1'b1);
        send_byte(1, 8'hAD, 1'b1);
        send_byte(1, 8'hBE, 1'b1);
        send_byte(1, 8'hEF, 1'b1);
        wait_cyc(5);
        n_checks++;
        if (wa1.size() !== 1 || wa1[0] !== 0 || wdq1[0] !== 32'hEFBE_ADDE)
            $display("FAIL frame_next_word: got %0d writes addr %0d data %h want 1 write addr 0 data efbeadde",
                     wa1.size(), (wa1.size() > 0) ? wa1[0] : -1, (wdq1.size() > 0) ? wdq1[0] : 32'hx);
        else n_pass++;
        n_checks++; if (fe1 !== 1'b1) $display("FAIL frame_err_sticky: got %b want 1", fe1); else n_pass++;
    endtask

    task automatic test_partial_flush();
        logic [7:0] bytes_v [6];
        bytes_v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        pe1 = 1'b0;
        wait_cyc(5);
        pe1 = 1'b1;
        wait_cyc(5);
        wa1.delete(); wdq1.delete();
        for (int i = 0; i < 6; i++) send_byte(1, bytes_v[i], 1'b1);
        wait_cyc(5);
        n_checks++;
        if (wa1.size() !== 1 || wa1[0] !== 0 || wdq1[0] !== 32'h4433_2211)
            $display("FAIL flush_first_word: got %0d writes data %h want 1 write addr 0 data 44332211",
                     wa1.size(), (wdq1.size() > 0) ? wdq1[0] : 32'hx);
        else n_pass++;
        pe1 = 1'b0;
        wait_cyc(3);
        n_checks++; if (we1 !== 1'b1) $display("FAIL flush_memWe: got %b want 1", we1); else n_pass++;
        n_checks++; if (addr1 !== 13'd1) $display("FAIL flush_addr: got %0d want 1", addr1); else n_pass++;
        n_checks++; if (wd1 !== 32'h0000_6655) $display("FAIL flush_data: got %h want 00006655", wd1); else n_pass++;
        n_checks++; if (crb1 !== 1'b0) $display("FAIL flush_cpuRstB_held: got %b want 0", crb1); else n_pass++;
        wait_cyc(1);
        n_checks++; if (we1 !== 1'b0) $display("FAIL flush_single_cycle: got %b want 0", we1); else n_pass++;
        n_checks++; if (crb1 !== 1'b1) $display("FAIL flush_cpuRstB_release: got %b want 1", crb1); else n_pass++;
        wait_cyc(5);
        n_checks++; if (wa1.size() !== 2) $display("FAIL flush_count: got %0d writes want 2", wa1.size()); else n_pass++;
    endtask

    task automatic test_wrap_restart();
        logic [31:0] exp_w;
        pe2 = 1'b1;
        wait_cyc(5);
        wa2.delete(); wdq2.delete();
        for (int i = 0; i < 20; i++) send_byte(2, 8'(i + 1), 1'b1);
        wait_cyc(5);
        n_checks++; if (wa2.size() !== 5) $display("FAIL wrap_count: got %0d writes want 5", wa2.size()); else n_pass++;
        for (int k = 0; k < 5 && k < wa2.size(); k++) begin
            exp_w = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
            n_checks++;
            if (wa2[k] !== (k % 4) || wdq2[k] !== exp_w)
                $display("FAIL wrap_word%0d: got addr %0d data %h want addr %0d data %h", k, wa2[k], wdq2[k], k % 4, exp_w);
            else n_pass++;
        end
        n_checks++; if (wc2 !== 3'd4) $display("FAIL wrap_wordCnt_sat: got %0d want 4", wc2); else n_pass++;
        send_byte(2, 8'h77, 1'b0);
        wait_cyc(5);
        n_checks++; if (fe2 !== 1'b1) $display("FAIL wrap_frameErr_set: got %b want 1", fe2); else n_pass++;
        pe2 = 1'b0;
        wait_cyc(10);
        pe2 = 1'b1;
        wait_cyc(5);
        n_checks++; if (wc2 !== 3'd0) $display("FAIL restart_wordCnt: got %0d want 0", wc2); else n_pass++;
        n_checks++; if (fe2 !== 1'b0) $display("FAIL restart_frameErr: got %b want 0", fe2); else n_pass++;
        n_checks++; if (wa2.size() !== 5) $display("FAIL restart_no_flush: got %0d writes want 5", wa2.size()); else n_pass++;
        wa2.delete(); wdq2.delete();
        send_byte(2, 8'hA1, 1'b1);
        send_byte(2, 8'hB2, 1'b1);
        send_byte(2, 8'hC3, 1'b1);
        send_byte(2, 8'hD4, 1'b1);
        wait_cyc(5);
        n_checks++;
        if (wa2.size() !== 1 || wa2[0] !== 0 || wdq2[0] !== 32'hD4C3_B2A1)
            $display("FAIL restart_first_write: got %0d writes addr %0d want 1 write addr 0 data d4c3b2a1",
                     wa2.size(), (wa2.size() > 0) ? wa2[0] : -1);
        else n_pass++;
        n_checks++; if (wc2 !== 3'd1) $display("FAIL restart_wordCnt_one: got %0d want 1", wc2); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_frame_glitch();
        test_partial_flush();
        test_wrap_restart();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_prog_loader.md
# uart_prog_loader

UART boot loader sitting between the SoC `rx` pin and the instruction-memory write port of `rv32i_top_Soc`. While `progEn` is high it receives 8N1 bytes and packs them little-endian into 32-bit words. It writes the words to consecutive word addresses starting at 0 and holds the CPU in reset. When `progEn` falls it flushes any partial word and then releases the CPU.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clocks per UART bit (100 MHz / 115200). Must be at least 4.
- `ADDR_W`, 13: word-address width (8192 words = 32 KiB).

Ports:
- `clk`, in, 1: single clock. One clock; all logic is in this domain.
- `rstB`, in, 1: reset, asynchronous, active-low.
- `progEn`, in, 1: programming mode, asynchronous to `clk`.
- `rx`, in, 1: UART serial input, idle high, asynchronous to `clk`.
- `memWe`, out, 1: one-cycle write strobe to instruction memory.
- `memAddr`, out, ADDR_W: word address; valid while `memWe` is high.
- `memWdata`, out, 32: write data; valid while `memWe` is high.
- `cpuRstB`, out, 1: active-low reset to the core.
- `frameErr`, out, 1: sticky flag, set by a bad stop bit.
- `wordCnt`, out, ADDR_W+1: number of words written in the current session.

## Operation
- **Synchronizers.** `rx` and `progEn` each pass through 2 flops. The `rx` flops reset to 1 and the `progEn` flops reset to 0. Only the synchronized versions (`rxS`, `progS`) are used below.
- **RX FSM states:** IDLE, START, DATA, STOP. A bit counter runs 0..CLKS_PER_BIT-1.
  - IDLE: waits for a falling edge on `rxS` (previous 1, current 0) while `progS` is 1. The edge starts the counter and moves to START.
  - START: after CLKS_PER_BIT/2 cycles (integer division), sample `rxS`. If 0, go to DATA. If 1, treat it as a glitch and return to IDLE.
  - DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register, LSB first. After 8 samples, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rxS`. If 1, the byte is valid. If 0, set `frameErr`, discard the byte, leave the byte lane unchanged, and go to IDLE. Both outcomes return to IDLE.
- **Packing.**
  - A valid byte is written to lane `lane` (2 bits), occupying bits [8*lane+7 : 8*lane] of the word buffer; `lane` then increments.
  - When lane 3 is written, the next cycle drives `memWe`=1 with `memAddr` = word pointer and `memWdata` = buffer.
  - After that write, the pointer increments, `lane` returns to 0 and the buffer clears to 0.
  - The pointer wraps from 2^ADDR_W-1 to 0. `wordCnt` saturates at 2^ADDR_W.
- **Session start** (rising edge of `progS`): pointer, `lane`, buffer, `wordCnt` and `frameErr` all clear.
- **Session end** (falling edge of `progS`):
  - The RX FSM is forced to IDLE and any byte in flight is abandoned.
  - If `lane` is nonzero, the next cycle issues one flush write of the buffer. Unfilled upper lanes are 0. The pointer then increments.
  - If `progS` rises and falls within one flush cycle, the flush still completes.
- **`cpuRstB`.** Low while `progS`=1 or a flush is pending or in progress. Otherwise high, registered.
- **Reset values.** `memWe`=0, `memAddr`=0, `memWdata`=0, `cpuRstB`=0, `frameErr`=0, `wordCnt`=0, FSM in IDLE, `lane`=0.
- **Reset mid-operation.** Asserting `rstB` at any time returns everything to the reset values immediately. Partial words are lost and no write is issued.

## Timing
- `rx` edge to `rxS` edge: 2 cycles.
- Stop sample: occurs 9*CLKS_PER_BIT + CLKS_PER_BIT/2 cycles after the `rxS` falling edge.
- `memWe` rises 1 cycle after the stop sample of the 4th byte. It is high for exactly 1 cycle.
- `progEn` falling to `progS` falling: 2 cycles. The flush `memWe` follows 1 cycle later.
- `cpuRstB` rises 1 cycle after `progS` falls when there is no flush, or 1 cycle after the flush `memWe` when there is one.
- Back-to-back bytes with zero idle time between the stop bit and the next start bit must be received without loss. IDLE re-arms in the cycle after the stop sample.
- `memWe` is never asserted while `progS`=0, except for the flush write.

## Test plan
- **Reset:** hold `rstB`=0 for 3 cycles with `rx`=1 and `progEn`=1. Required: all outputs at their reset values, then `cpuRstB` stays 0 after release.
- **Single word:** send bytes 0x13,0x00,0x00,0x00 at 868 clocks/bit. Required: one `memWe` with `memAddr`=0 and `memWdata`=0x00000013, and `wordCnt`=1.
- **256-byte image:** send 256 bytes (including 0xFF, 0x00, 0xA5) back-to-back, then drop `progEn`. Required:
  - 64 writes at addresses 0..63, each with the correct little-endian data.
  - No flush write.
  - `cpuRstB`=1 three cycles after `progEn` falls.
- **Framing error and glitch:**
  - A byte with stop bit 0 sets `frameErr` and produces no lane advance.
  - A 100-cycle low pulse on `rx` is rejected as a glitch, with no byte received.
  - The next valid 4 bytes still produce a write to address 0.
- **Partial flush:** send 0x11,0x22,0x33,0x44,0x55,0x66, then drop `progEn`. Required:
  - Writes 0x44332211 at address 0 and 0x00006655 at address 1.
  - `cpuRstB` rises 1 cycle after the second write.
- **Wrap and session restart:** with ADDR_W=2, send 20 bytes. Required:
  - Writes at addresses 0,1,2,3,0.
  - `wordCnt` saturates at 4.
  - After re-raising `progEn`, `wordCnt`=0, `frameErr`=0 and the next write goes to address 0.
